// File: rtl/array_writer_pkg.sv
// Shared types and sizing helpers for the indexed array writer.
package array_writer_pkg;

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_t;

  localparam int DEFAULT_DEPTH = 5;
  localparam int DEFAULT_WIDTH = 4;

  // A one-element array still needs a 1-bit index port.
  function automatic int idx_width(input int depth);
    int w;
    w = $clog2(depth);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/array_elem_writer_if.sv
// Element-write source port plus packed-array publish port of the array writer.
interface array_elem_writer_if
  import array_writer_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int WIDTH = DEFAULT_WIDTH
);
  localparam int IDX_W = idx_width(DEPTH);

  // Both channels: a transfer happens on a rising edge where valid && ready;
  // the sender holds its payload until then, and ready never depends on valid.
  logic                   wr_valid;
  logic                   wr_ready;
  logic [IDX_W-1:0]       wr_idx;
  logic [WIDTH-1:0]       wr_data;
  logic                   out_valid;
  logic                   out_ready;
  logic [DEPTH*WIDTH-1:0] out_arr;

  modport slave (
    input  wr_valid, wr_idx, wr_data, out_ready,
    output wr_ready, out_valid, out_arr
  );

  modport master (
    output wr_valid, wr_idx, wr_data, out_ready,
    input  wr_ready, out_valid, out_arr
  );

endinterface

// File: rtl/array_fill_tracker.sv
// Tracks which array elements have been written since the last publish.
module array_fill_tracker #(
  parameter int DEPTH = 5,
  parameter int IDX_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             set_en,
  input  logic [IDX_W-1:0] set_idx,
  input  logic             clr_en,
  output logic             full_next,
  output logic             in_range,
  output logic             dup
);

  logic [DEPTH-1:0] bitmap_q;
  logic [DEPTH-1:0] bitmap_d;
  logic [DEPTH-1:0] onehot;
  logic [DEPTH-1:0] merged;
  logic             take;

  // An out-of-range index decodes to an all-zero one-hot.
  always_comb begin
    onehot = '0;
    for (int i = 0; i < DEPTH; i++) begin
      onehot[i] = (32'(set_idx) == 32'(i));
    end
  end

  assign in_range  = (32'(set_idx) < 32'(DEPTH));
  assign take      = set_en && in_range;
  assign merged    = bitmap_q | onehot;
  assign full_next = take && (&merged);
  assign dup       = take && (|(bitmap_q & onehot));

  always_comb begin
    bitmap_d = bitmap_q;
    if (clr_en) begin
      bitmap_d = '0;
    end else if (take) begin
      bitmap_d = merged;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bitmap_q <= '0;
    end else begin
      bitmap_q <= bitmap_d;
    end
  end

endmodule

// File: rtl/array_elem_writer.sv
// Collects indexed element writes into a register array and publishes it whole.
// Optional ARRAY_ELEM_WRITER_DUP_ERR_EN adds a sticky dup_err output.
module array_elem_writer
  import array_writer_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                clk,
  input  logic                rst,
  array_elem_writer_if.slave  bus,
  output state_t              state_dbg,
  output logic                idx_err
`ifdef ARRAY_ELEM_WRITER_DUP_ERR_EN
  ,
  output logic                dup_err
`endif
);

  localparam int IDX_W = idx_width(DEPTH);

  state_t                       state_q, state_d;
  logic [DEPTH-1:0][WIDTH-1:0]  elems_q, elems_d;
  logic                         idx_err_q, idx_err_d;
  logic                         set_en, clr_en;
  logic                         full_next, in_range, dup;

  assign set_en = (state_q == FILL) && bus.wr_valid;
  assign clr_en = (state_q == HOLD) && bus.out_ready;

  array_fill_tracker #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_tracker (
    .clk       (clk),
    .rst       (rst),
    .set_en    (set_en),
    .set_idx   (bus.wr_idx),
    .clr_en    (clr_en),
    .full_next (full_next),
    .in_range  (in_range),
    .dup       (dup)
  );

  always_comb begin
    state_d   = state_q;
    elems_d   = elems_q;
    idx_err_d = idx_err_q;
    case (state_q)
      FILL: begin
        if (bus.wr_valid) begin
          if (in_range) begin
            for (int i = 0; i < DEPTH; i++) begin
              if (32'(bus.wr_idx) == 32'(i)) elems_d[i] = bus.wr_data;
            end
          end else begin
            idx_err_d = 1'b1;
          end
          if (full_next) state_d = HOLD;
        end
      end
      HOLD: begin
        // Storage is kept so out_arr shows the last array until overwritten.
        if (bus.out_ready) state_d = FILL;
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= FILL;
      elems_q   <= '0;
      idx_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      elems_q   <= elems_d;
      idx_err_q <= idx_err_d;
    end
  end

`ifdef ARRAY_ELEM_WRITER_DUP_ERR_EN
  logic dup_err_q, dup_err_d;

  always_comb begin
    dup_err_d = dup_err_q;
    if (dup) dup_err_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dup_err_q <= 1'b0;
    end else begin
      dup_err_q <= dup_err_d;
    end
  end

  assign dup_err = dup_err_q;
`else
  logic unused_dup;
  assign unused_dup = dup;
`endif

  assign bus.wr_ready  = (state_q == FILL);
  assign bus.out_valid = (state_q == HOLD);
  assign bus.out_arr   = elems_q;
  assign idx_err       = idx_err_q;
  assign state_dbg     = state_q;

endmodule

// File: tb/tb_array_elem_writer.sv
// Directed bench for array_elem_writer: fill orders, hold stall, bad index,
// duplicates and mid-operation reset.
module tb_array_elem_writer;
  import array_writer_pkg::*;

  localparam int DEPTH = 5;
  localparam int WIDTH = 4;
  localparam int AW    = DEPTH * WIDTH;

  logic   clk = 1'b0;
  logic   rst;
  state_t state_dbg;
  logic   idx_err;
`ifdef ARRAY_ELEM_WRITER_DUP_ERR_EN
  logic   dup_err;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  array_elem_writer_if #(.DEPTH(DEPTH), .WIDTH(WIDTH)) bus ();

  array_elem_writer #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .state_dbg (state_dbg),
    .idx_err   (idx_err)
`ifdef ARRAY_ELEM_WRITER_DUP_ERR_EN
    ,
    .dup_err   (dup_err)
`endif
  );

  // One clock: inputs change and outputs are sampled on the falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic write_elem(input logic [2:0] idx, input logic [3:0] d);
    total++;
    if (bus.wr_ready !== 1'b1) begin
      bad++;
      $display("FAIL wr_ready_before_write idx=%0d: got %b want 1", idx, bus.wr_ready);
    end
    bus.wr_valid = 1'b1;
    bus.wr_idx   = idx;
    bus.wr_data  = d;
    step();
    bus.wr_valid = 1'b0;
  endtask

  task automatic release_arr();
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    total++; if (bus.wr_ready !== 1'b1) begin bad++; $display("FAIL reset_wr_ready: got %b want 1", bus.wr_ready); end
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
    total++; if (bus.out_arr !== 20'h0) begin bad++; $display("FAIL reset_out_arr: got %h want 00000", bus.out_arr); end
    total++; if (idx_err !== 1'b0) begin bad++; $display("FAIL reset_idx_err: got %b want 0", idx_err); end
    total++; if (state_dbg !== FILL) begin bad++; $display("FAIL reset_state: got %0d want FILL", state_dbg); end
    rst = 1'b0;
  endtask

  task automatic test_in_order();
    for (int i = 0; i < 4; i++) write_elem(3'(i), 4'(i + 1));
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL inorder_early_valid: got %b want 0", bus.out_valid); end
    write_elem(3'd4, 4'd5);
    total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL inorder_valid: got %b want 1", bus.out_valid); end
    total++; if (bus.out_arr !== 20'h54321) begin bad++; $display("FAIL inorder_arr: got %h want 54321", bus.out_arr); end
    total++; if (bus.wr_ready !== 1'b0) begin bad++; $display("FAIL inorder_wr_ready: got %b want 0", bus.wr_ready); end
    release_arr();
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL inorder_release_valid: got %b want 0", bus.out_valid); end
    total++; if (bus.wr_ready !== 1'b1) begin bad++; $display("FAIL inorder_release_ready: got %b want 1", bus.wr_ready); end
    total++; if (bus.out_arr !== 20'h54321) begin bad++; $display("FAIL inorder_arr_kept: got %h want 54321", bus.out_arr); end
  endtask

  task automatic test_any_order();
    write_elem(3'd3, 4'hA);
    write_elem(3'd1, 4'hB);
    write_elem(3'd4, 4'hC);
    write_elem(3'd0, 4'hD);
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL anyorder_early_valid: got %b want 0", bus.out_valid); end
    write_elem(3'd2, 4'hE);
    total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL anyorder_valid: got %b want 1", bus.out_valid); end
    total++; if (bus.out_arr !== 20'hCAEBD) begin bad++; $display("FAIL anyorder_arr: got %h want CAEBD", bus.out_arr); end
  endtask

  task automatic test_hold_stall();
    bus.out_ready = 1'b0;
    bus.wr_valid  = 1'b1;
    bus.wr_idx    = 3'd0;
    bus.wr_data   = 4'hF;
    for (int c = 0; c < 5; c++) begin
      step();
      total++; if (bus.out_arr !== 20'hCAEBD) begin bad++; $display("FAIL hold_arr cyc=%0d: got %h want CAEBD", c, bus.out_arr); end
      total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL hold_valid cyc=%0d: got %b want 1", c, bus.out_valid); end
      total++; if (bus.wr_ready !== 1'b0) begin bad++; $display("FAIL hold_wr_ready cyc=%0d: got %b want 0", c, bus.wr_ready); end
    end
    bus.wr_valid = 1'b0;
    total++; if (idx_err !== 1'b0) begin bad++; $display("FAIL hold_idx_err: got %b want 0", idx_err); end
    release_arr();
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL hold_release_valid: got %b want 0", bus.out_valid); end
    total++; if (bus.wr_ready !== 1'b1) begin bad++; $display("FAIL hold_release_ready: got %b want 1", bus.wr_ready); end
    total++; if (bus.out_arr !== 20'hCAEBD) begin bad++; $display("FAIL hold_release_arr: got %h want CAEBD", bus.out_arr); end
  endtask

  task automatic test_bad_idx();
    write_elem(3'd6, 4'd7);
    total++; if (idx_err !== 1'b1) begin bad++; $display("FAIL badidx_err: got %b want 1", idx_err); end
    total++; if (state_dbg !== FILL) begin bad++; $display("FAIL badidx_state: got %0d want FILL", state_dbg); end
    total++; if (bus.out_arr !== 20'hCAEBD) begin bad++; $display("FAIL badidx_arr: got %h want CAEBD", bus.out_arr); end
    for (int i = 0; i < 4; i++) write_elem(3'(i), 4'(i + 8));
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL badidx_early_valid: got %b want 0", bus.out_valid); end
    write_elem(3'd4, 4'hC);
    total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL badidx_valid: got %b want 1", bus.out_valid); end
    total++; if (bus.out_arr !== 20'hCBA98) begin bad++; $display("FAIL badidx_arr_pub: got %h want CBA98", bus.out_arr); end
    total++; if (idx_err !== 1'b1) begin bad++; $display("FAIL badidx_sticky: got %b want 1", idx_err); end
    release_arr();
  endtask

  task automatic test_dup();
`ifdef ARRAY_ELEM_WRITER_DUP_ERR_EN
    total++; if (dup_err !== 1'b0) begin bad++; $display("FAIL dup_err_before: got %b want 0", dup_err); end
`endif
    write_elem(3'd0, 4'd1);
    write_elem(3'd0, 4'd9);
    write_elem(3'd1, 4'd2);
    write_elem(3'd2, 4'd3);
    write_elem(3'd3, 4'd4);
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL dup_early_valid: got %b want 0", bus.out_valid); end
    write_elem(3'd4, 4'd5);
    total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL dup_valid: got %b want 1", bus.out_valid); end
    total++; if (bus.out_arr !== 20'h54329) begin bad++; $display("FAIL dup_arr: got %h want 54329", bus.out_arr); end
`ifdef ARRAY_ELEM_WRITER_DUP_ERR_EN
    total++; if (dup_err !== 1'b1) begin bad++; $display("FAIL dup_err_after: got %b want 1", dup_err); end
`endif
    release_arr();
  endtask

  task automatic test_mid_reset();
    write_elem(3'd0, 4'd1);
    write_elem(3'd1, 4'd2);
    write_elem(3'd2, 4'd3);
    rst = 1'b1;
    step();
    rst = 1'b0;
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL midrst_valid: got %b want 0", bus.out_valid); end
    total++; if (idx_err !== 1'b0) begin bad++; $display("FAIL midrst_idx_err: got %b want 0", idx_err); end
    total++; if (bus.out_arr !== 20'h0) begin bad++; $display("FAIL midrst_arr: got %h want 00000", bus.out_arr); end
    total++; if (bus.wr_ready !== 1'b1) begin bad++; $display("FAIL midrst_ready: got %b want 1", bus.wr_ready); end
    bus.out_ready = 1'b1;
    write_elem(3'd3, 4'd6);
    write_elem(3'd4, 4'd7);
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL midrst_two_valid: got %b want 0", bus.out_valid); end
    write_elem(3'd0, 4'd1);
    write_elem(3'd1, 4'd2);
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL midrst_four_valid: got %b want 0", bus.out_valid); end
    bus.out_ready = 1'b0;
    write_elem(3'd2, 4'd3);
    total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL midrst_pub_valid: got %b want 1", bus.out_valid); end
    total++; if (bus.out_arr !== 20'h76321) begin bad++; $display("FAIL midrst_pub_arr: got %h want 76321", bus.out_arr); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL holdrst_valid: got %b want 0", bus.out_valid); end
    total++; if (bus.out_arr !== 20'h0) begin bad++; $display("FAIL holdrst_arr: got %h want 00000", bus.out_arr); end
    total++; if (bus.wr_ready !== 1'b1) begin bad++; $display("FAIL holdrst_ready: got %b want 1", bus.wr_ready); end
  endtask

  initial begin
    bus.wr_valid  = 1'b0;
    bus.wr_idx    = '0;
    bus.wr_data   = '0;
    bus.out_ready = 1'b0;
    rst           = 1'b1;
    @(negedge clk);
    test_reset();
    test_in_order();
    test_any_order();
    test_hold_stall();
    test_bad_idx();
    test_dup();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
